taxi_eth_tx_gbx_66_64: RTL and testbench
========================================

Name: taxi_eth_tx_gbx_66_64

Overview:
- 66:64 transmit gearbox between the 10G PHY TX SERDES interface (64-bit block plus 2-bit sync header, gearbox-interface mode) and a raw 64-bit transceiver TX data port.
- Owns the 33-cycle gearbox sequence and drives the PHY's serdes_tx_gbx_req_start and serdes_tx_gbx_req_stall inputs.
- Absorbs one block per cycle except on the stall cycle, and emits one 64-bit word every cycle.

Parameters:
- DATA_W, 64, block payload width; only 64 supported.
- HDR_W, 2, sync header width; only 2 supported.
- SEQ_LEN, 33, cycles per gearbox sequence (= (DATA_W+HDR_W)/HDR_W).

Ports:
- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- serdes_tx_data  in  64  block payload from PHY.
- serdes_tx_data_valid  in  1  payload valid.
- serdes_tx_hdr  in  2  sync header from PHY.
- serdes_tx_hdr_valid  in  1  header valid.
- serdes_tx_gbx_start  in  1  PHY marks block as first of sequence.
- serdes_tx_gbx_req_start  out  1  sequence-start request to PHY.
- serdes_tx_gbx_req_stall  out  1  stall request to PHY.
- gt_tx_data  out  64  raw word to transceiver; bit 0 is transmitted first.
- gt_tx_data_valid  out  1  word is a gearboxed word, not post-reset fill.
- stat_seq_err  out  1  one-cycle pulse on sequence misalignment.
- stat_stall_err  out  1  one-cycle pulse on valid data presented in the stall cycle.
- stat_underflow  out  1  one-cycle pulse on missing data in a non-stall cycle.

Behaviour:
- Reset values (async assert, sync release): all outputs 0; seq_cnt=0; residue register (64 bits) = 0; residue length = 0.
- seq_cnt counts 0..32 and wraps 32->0 every cycle after reset release; it never stalls.
- serdes_tx_gbx_req_start is combinational, = (seq_cnt==0).
- serdes_tx_gbx_req_stall is combinational, = (seq_cnt==32).
- The PHY presents its block in the same cycle as the request (zero lead).
- Block bit vector is B[65:0] = {data, hdr}: header in B[1:0], sent first.
- Cycle with seq_cnt=k, k in 0..31, assuming a block is accepted:
  - Residue holds 2k bits.
  - Output word = low 64 bits of {B, residue[2k-1:0]}.
  - New residue = the upper 2k+2 bits of that concatenation.
- Cycle with seq_cnt=32: output word = residue[63:0]; residue cleared; input ignored.
- gt_tx_data and gt_tx_data_valid are registered: 1-cycle latency from the input cycle.
- gt_tx_data_valid stays 0 until the first accepted block with serdes_tx_gbx_start=1 and seq_cnt==0. It then stays 1 until reset.
- Block accepted when data_valid && hdr_valid && seq_cnt!=32.
- Valid mismatch: data_valid != hdr_valid in any cycle is treated as not-valid and pulses stat_underflow.
- Underflow: no accepted block at seq_cnt 0..31.
  - Substitute block B = 66'h0 (all zeros) to keep the bit count; the receiver loses lock, which is intended.
  - stat_underflow pulses in the output cycle.
- Stall error: valid data at seq_cnt==32. Data is dropped and stat_stall_err pulses.
- Sequence error: an accepted block with serdes_tx_gbx_start=1 and seq_cnt!=0.
  - stat_seq_err pulses; the block is still shifted normally.
  - No realignment: the gearbox is the sequence master.
- serdes_tx_gbx_start=0 at seq_cnt==0 with a valid block is also a sequence error.
- Reset mid-sequence: counter, residue and gt_tx_data_valid clear immediately; req_start is high in the first cycle after release.

Decomposition:
- Add to taxi_eth_pkg (or the existing 10G PHY package):
  - localparams GBX_SEQ_LEN=33 and GBX_BLK_W=66.
  - typedef gbx_seq_t (logic [5:0]).
- Sub-module taxi_eth_gbx_seq_cnt: sequence counter plus req_start/req_stall decode, reusable by a future RX 64:66 gearbox.
- Shift datapath stays inline.

Test Plan:
- Reset release, PHY model obeys req_start/req_stall and sends 32 blocks per sequence -> gt_tx_data_valid rises 1 cycle after the first start block.
  - Concatenating all output bits reproduces the exact 66-bit block stream; a 2112-bit sequence yields exactly 33 words.
- Block k = {64'(k), 2'b01}, k=0..31 -> word 0 = {data0[61:0], 2'b01}; word 32 = residue from block 31 = block31[65:2].
  - No stat pulses.
- Valid data held high at seq_cnt 32 -> stat_stall_err pulses once per sequence; output stream is unchanged versus the compliant case.
- data_valid=0 at seq_cnt 5 -> stat_underflow pulses in the next cycle.
  - 66 zero bits are inserted at the block-5 position; the following sequence is realigned with no further errors.
- serdes_tx_gbx_start=1 at seq_cnt 7 -> stat_seq_err pulses once; seq_cnt continues and req_start reasserts at the next wrap.
- rst_n asserted at seq_cnt 20 for 3 cycles -> all outputs are 0 immediately (async).
  - After release, req_start=1 in the first cycle; gt_tx_data_valid stays 0 until the next start block.

Source files
------------

// File: rtl/taxi_eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_pkg
//  Description : Shared constants and types for the 10G Ethernet PHY path.
//                Holds the 66:64 gearbox sequence length, the encoded block
//                width and the sequence counter type.
//  Revision    : 1.0  initial release
// ============================================================================
package taxi_eth_pkg;

   localparam int GBX_SEQ_LEN = 33;   // blocks+stall cycles per gearbox sequence
   localparam int GBX_BLK_W   = 66;   // 64-bit payload plus 2-bit sync header

   typedef logic [5:0] gbx_seq_t;

endpackage : taxi_eth_pkg
`default_nettype wire

// File: rtl/taxi_eth_gbx_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_gbx_seq_cnt
//  Description : Free-running gearbox sequence counter (0..SEQ_LEN-1) with
//                decode of the PHY sequence-start and stall requests.
//  Ports       : clk, rst_n        clock, async active-low reset
//                o_seq_cnt         current position in the sequence
//                o_req_start       high at position 0 (outside reset)
//                o_req_stall       high at the last position
//  Revision    : 1.0  initial release
// ============================================================================
module taxi_eth_gbx_seq_cnt
   import taxi_eth_pkg::*;
#(
   parameter int SEQ_LEN = GBX_SEQ_LEN
) (
   input  logic     clk,
   input  logic     rst_n,
   output gbx_seq_t o_seq_cnt,
   output logic     o_req_start,
   output logic     o_req_stall
);

   localparam gbx_seq_t c_LAST = gbx_seq_t'(SEQ_LEN - 1);

   gbx_seq_t r_seq_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_cnt <= '0;
      end else if (r_seq_cnt == c_LAST) begin
         r_seq_cnt <= '0;
      end else begin
         r_seq_cnt <= r_seq_cnt + gbx_seq_t'(1);
      end
   end

   assign o_seq_cnt   = r_seq_cnt;
   // Held low while in reset so every output of the gearbox reads zero then;
   // the counter already sits at 0, so the first cycle after release requests.
   assign o_req_start = rst_n && (r_seq_cnt == '0);
   assign o_req_stall = (r_seq_cnt == c_LAST);

endmodule : taxi_eth_gbx_seq_cnt
`default_nettype wire

// File: rtl/taxi_eth_tx_gbx_66_64.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_tx_gbx_66_64
//  Description : 66:64 transmit gearbox. Packs one 66-bit block per cycle
//                (none in the stall cycle) into one 64-bit word per cycle,
//                acting as sequence master towards the PHY.
//  Ports       : clk, rst_n                  clock, async active-low reset
//                serdes_tx_data/_valid       block payload from PHY
//                serdes_tx_hdr/_valid        sync header from PHY
//                serdes_tx_gbx_start         PHY marks first block of sequence
//                serdes_tx_gbx_req_start     sequence-start request to PHY
//                serdes_tx_gbx_req_stall     stall request to PHY
//                gt_tx_data/_valid           raw word to transceiver (bit 0 first)
//                stat_seq_err/_stall_err/_underflow   one-cycle error pulses
//  Revision    : 1.0  initial release
// ============================================================================
module taxi_eth_tx_gbx_66_64
   import taxi_eth_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int HDR_W   = 2,
   parameter int SEQ_LEN = GBX_SEQ_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] serdes_tx_data,
   input  logic              serdes_tx_data_valid,
   input  logic [HDR_W-1:0]  serdes_tx_hdr,
   input  logic              serdes_tx_hdr_valid,
   input  logic              serdes_tx_gbx_start,
   output logic              serdes_tx_gbx_req_start,
   output logic              serdes_tx_gbx_req_stall,
   output logic [DATA_W-1:0] gt_tx_data,
   output logic              gt_tx_data_valid,
   output logic              stat_seq_err,
   output logic              stat_stall_err,
   output logic              stat_underflow
);

   localparam int c_BLK_W = DATA_W + HDR_W;
   localparam int c_CAT_W = 2 * DATA_W;

   gbx_seq_t            w_seq_cnt;
   logic                w_req_start;
   logic                w_req_stall;
   logic                w_both_valid;
   logic                w_accept;
   logic [c_BLK_W-1:0]  w_blk;
   logic [6:0]          w_shift;
   logic [c_CAT_W-1:0]  w_cat;

   logic [DATA_W-1:0]   r_res;
   logic [DATA_W-1:0]   r_gt_data;
   logic                r_gt_valid;
   logic                r_seq_err;
   logic                r_stall_err;
   logic                r_underflow;

   taxi_eth_gbx_seq_cnt #(
      .SEQ_LEN     (SEQ_LEN)
   ) u_seq_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .o_seq_cnt   (w_seq_cnt),
      .o_req_start (w_req_start),
      .o_req_stall (w_req_stall)
   );

   assign w_both_valid = serdes_tx_data_valid && serdes_tx_hdr_valid;
   assign w_accept     = w_both_valid && !w_req_stall;

   // A missing block becomes all zeros so the bit count per sequence holds.
   assign w_blk   = w_accept ? {serdes_tx_data, serdes_tx_hdr} : '0;

   // Residue holds 2k valid bits at position k; bits above that are always
   // zero, so the new block can be OR-ed in directly above them.
   assign w_shift = {w_seq_cnt, 1'b0};
   assign w_cat   = (c_CAT_W'(w_blk) << w_shift) | c_CAT_W'(r_res);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res       <= '0;
         r_gt_data   <= '0;
         r_gt_valid  <= 1'b0;
         r_seq_err   <= 1'b0;
         r_stall_err <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_req_stall) begin
            // Residue is exactly 64 bits here: flush it as a whole word.
            r_gt_data <= r_res;
            r_res     <= '0;
         end else begin
            r_gt_data <= w_cat[DATA_W-1:0];
            r_res     <= w_cat[c_CAT_W-1:DATA_W];
         end
         r_gt_valid  <= r_gt_valid ||
                        (w_accept && serdes_tx_gbx_start && (w_seq_cnt == '0));
         r_seq_err   <= w_accept && (serdes_tx_gbx_start != (w_seq_cnt == '0));
         r_stall_err <= w_req_stall && w_both_valid;
         r_underflow <= (!w_req_stall && !w_accept) ||
                        (serdes_tx_data_valid != serdes_tx_hdr_valid);
      end
   end

   assign serdes_tx_gbx_req_start = w_req_start;
   assign serdes_tx_gbx_req_stall = w_req_stall;
   assign gt_tx_data              = r_gt_data;
   assign gt_tx_data_valid        = r_gt_valid;
   assign stat_seq_err            = r_seq_err;
   assign stat_stall_err          = r_stall_err;
   assign stat_underflow          = r_underflow;

endmodule : taxi_eth_tx_gbx_66_64
`default_nettype wire

// File: tb/tb_taxi_eth_tx_gbx_66_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_taxi_eth_tx_gbx_66_64
//  Description : Self-checking bench for the 66:64 transmit gearbox. A PHY
//                model drives blocks; a bit-stream reference model predicts
//                every output word and status pulse through a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_taxi_eth_tx_gbx_66_64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] serdes_tx_data;
   logic        serdes_tx_data_valid;
   logic [1:0]  serdes_tx_hdr;
   logic        serdes_tx_hdr_valid;
   logic        serdes_tx_gbx_start;
   logic        serdes_tx_gbx_req_start;
   logic        serdes_tx_gbx_req_stall;
   logic [63:0] gt_tx_data;
   logic        gt_tx_data_valid;
   logic        stat_seq_err;
   logic        stat_stall_err;
   logic        stat_underflow;

   always #5 clk = ~clk;

   taxi_eth_tx_gbx_66_64 dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .serdes_tx_data          (serdes_tx_data),
      .serdes_tx_data_valid    (serdes_tx_data_valid),
      .serdes_tx_hdr           (serdes_tx_hdr),
      .serdes_tx_hdr_valid     (serdes_tx_hdr_valid),
      .serdes_tx_gbx_start     (serdes_tx_gbx_start),
      .serdes_tx_gbx_req_start (serdes_tx_gbx_req_start),
      .serdes_tx_gbx_req_stall (serdes_tx_gbx_req_stall),
      .gt_tx_data              (gt_tx_data),
      .gt_tx_data_valid        (gt_tx_data_valid),
      .stat_seq_err            (stat_seq_err),
      .stat_stall_err          (stat_stall_err),
      .stat_underflow          (stat_underflow)
   );

   typedef struct packed {
      logic [63:0] word;
      logic        valid;
      logic        seq;
      logic        stall;
      logic        uf;
   } exp_t;

   typedef struct {
      int   bad_k;
      logic dv;
      logic hv;
      logic st;
      int   exp_seq;
      int   exp_stall;
      int   exp_uf;
   } vec_t;

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model state: pending transmit bits (LSB first), position, valid.
   bit   mq[$];
   int   mk     = 0;
   logic mvalid = 1'b0;
   exp_t sb[$];

   int obs_seq, obs_stall, obs_uf;
   logic [63:0] wcap [0:32];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      mk     = 0;
      mvalid = 1'b0;
   endtask

   task automatic model(input logic dv, input logic hv, input logic st,
                        input logic [63:0] d, input logic [1:0] h, output exp_t e);
      logic [65:0] blk;
      logic        acc;
      e = '0;
      if (mk == 32) begin
         e.stall = dv && hv;
         e.uf    = (dv != hv);
      end else begin
         acc = dv && hv;
         blk = acc ? {d, h} : 66'd0;
         for (int i = 0; i < 66; i++) mq.push_back(blk[i]);
         e.uf  = !acc || (dv != hv);
         e.seq = acc && (st != (mk == 0));
         if (acc && st && (mk == 0)) mvalid = 1'b1;
      end
      for (int i = 0; i < 64; i++) e.word[i] = (mq.size() > 0) ? mq.pop_front() : 1'b0;
      e.valid = mvalid;
      mk = (mk == 32) ? 0 : mk + 1;
   endtask

   // One clock: drive at the falling edge, compare just after the rising edge.
   task automatic step(input logic dv, input logic hv, input logic st,
                       input logic [63:0] d, input logic [1:0] h);
      exp_t e;
      @(negedge clk);
      chk("req_start", 64'(serdes_tx_gbx_req_start), 64'(mk == 0));
      chk("req_stall", 64'(serdes_tx_gbx_req_stall), 64'(mk == 32));
      serdes_tx_data       = d;
      serdes_tx_hdr        = h;
      serdes_tx_data_valid = dv;
      serdes_tx_hdr_valid  = hv;
      serdes_tx_gbx_start  = st;
      model(dv, hv, st, d, h, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk("gt_tx_data",       gt_tx_data,            e.word);
         chk("gt_tx_data_valid", 64'(gt_tx_data_valid), 64'(e.valid));
         chk("stat_seq_err",     64'(stat_seq_err),     64'(e.seq));
         chk("stat_stall_err",   64'(stat_stall_err),   64'(e.stall));
         chk("stat_underflow",   64'(stat_underflow),   64'(e.uf));
      end
      obs_seq   += int'(stat_seq_err);
      obs_stall += int'(stat_stall_err);
      obs_uf    += int'(stat_underflow);
   endtask

   // Compliant PHY, with one optional override at position bad_k.
   task automatic phy_step(input int bad_k, input logic bdv, input logic bhv,
                           input logic bst, input bit ramp, input bit nostart);
      logic        dv, hv, st;
      logic [63:0] d;
      logic [1:0]  h;
      d = ramp ? 64'(mk) : {$urandom(), $urandom()};
      h = ramp ? 2'b01 : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      if (mk == 32) begin
         dv = 1'b0; hv = 1'b0; st = 1'b0;
      end else begin
         dv = 1'b1; hv = 1'b1; st = (mk == 0) && !nostart;
      end
      if (mk == bad_k) begin
         dv = bdv; hv = bhv; st = bst;
      end
      step(dv, hv, st, d, h);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gt_tx_data"},  gt_tx_data,                    64'd0);
      chk({tag, "_gt_valid"},    64'(gt_tx_data_valid),         64'd0);
      chk({tag, "_stats"},       64'({stat_seq_err, stat_stall_err, stat_underflow}), 64'd0);
      chk({tag, "_req_start"},   64'(serdes_tx_gbx_req_start),  64'd0);
      chk({tag, "_req_stall"},   64'(serdes_tx_gbx_req_stall),  64'd0);
   endtask

   vec_t vecs [0:8];

   initial begin
      vecs[0] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0, 0};   // compliant
      vecs[1] = '{32, 1'b1, 1'b1, 1'b0, 0, 1, 0};   // valid data in stall cycle
      vecs[2] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      vecs[3] = '{ 5, 1'b0, 1'b0, 1'b0, 0, 0, 1};   // underflow at 5
      vecs[4] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0, 0};   // realigned, clean
      vecs[5] = '{ 7, 1'b1, 1'b1, 1'b1, 1, 0, 0};   // start at 7
      vecs[6] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      vecs[7] = '{10, 1'b1, 1'b0, 1'b0, 0, 0, 1};   // valid mismatch
      vecs[8] = '{ 0, 1'b1, 1'b1, 1'b0, 1, 0, 0};   // missing start at 0

      rst_n                = 1'b0;
      serdes_tx_data       = '0;
      serdes_tx_hdr        = '0;
      serdes_tx_data_valid = 1'b0;
      serdes_tx_hdr_valid  = 1'b0;
      serdes_tx_gbx_start  = 1'b0;
      obs_seq = 0; obs_stall = 0; obs_uf = 0;

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      model_reset();

      // First sequence: ramp blocks {64'(k), 2'b01}
      for (int k = 0; k < 33; k++) begin
         phy_step(-1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         wcap[k] = gt_tx_data;
      end
      chk("ramp_word0",  wcap[0],  64'h0000_0000_0000_0001);
      chk("ramp_word1",  wcap[1],  64'h0000_0000_0000_0014);
      chk("ramp_word32", wcap[32], 64'h0000_0000_0000_001F);
      chk("ramp_pulses", 64'(obs_seq + obs_stall + obs_uf), 64'd0);

      for (int v = 0; v < 9; v++) begin
         obs_seq = 0; obs_stall = 0; obs_uf = 0;
         for (int c = 0; c < 33; c++)
            phy_step(vecs[v].bad_k, vecs[v].dv, vecs[v].hv, vecs[v].st, 1'b0, 1'b0);
         chk($sformatf("vec%0d_seq_cnt",   v), 64'(obs_seq),   64'(vecs[v].exp_seq));
         chk($sformatf("vec%0d_stall_cnt", v), 64'(obs_stall), 64'(vecs[v].exp_stall));
         chk($sformatf("vec%0d_uf_cnt",    v), 64'(obs_uf),    64'(vecs[v].exp_uf));
      end

      // Reset asserted asynchronously at position 20 for 3 cycles
      for (int c = 0; c < 20; c++) phy_step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_reset_valid", 64'(gt_tx_data_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("held_rst");
      rst_n = 1'b1;
      model_reset();

      // No start marker for a whole sequence: data stays not-valid
      obs_seq = 0;
      for (int c = 0; c < 33; c++) phy_step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("nostart_valid",   64'(gt_tx_data_valid), 64'd0);
      chk("nostart_seq_cnt", 64'(obs_seq),          64'd1);

      // Next start block brings the output valid
      for (int c = 0; c < 33; c++) phy_step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_valid", 64'(gt_tx_data_valid), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule : tb_taxi_eth_tx_gbx_66_64
`default_nettype wire
